// File: rtl/solar_sensor_sampler_pkg.sv
// Shared definitions for the solar sensor sampler.
// Holds the sensor width, the channel indices, the tracker hysteresis and the
// sampler FSM state encoding.
package solar_pkg;

  localparam int SENS_W = 8;

  // Tracker hysteresis, shared with the downstream tracker FSM.
  localparam int TH = 4;

  localparam logic [1:0] CH_N = 2'd0;
  localparam logic [1:0] CH_E = 2'd1;
  localparam logic [1:0] CH_S = 2'd2;
  localparam logic [1:0] CH_W = 2'd3;

  typedef enum logic [2:0] {
    S_SEL    = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_ACC    = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

endpackage

// File: rtl/solar_sensor_sampler_if.sv
// ADC-side and tracker-side signal bundle of the solar sensor sampler.
// master: the sampler (drives mux select, start and the filtered levels).
// slave : the ADC and tracker side (drives conversion data and done).
interface solar_sensor_sampler_if;
  import solar_pkg::*;

  logic [SENS_W-1:0] adc_data;   // conversion result, valid with adc_done
  logic              adc_done;   // one-cycle conversion-complete pulse
  logic [1:0]        adc_sel;    // mux channel 0=N 1=E 2=S 3=W
  logic              adc_start;  // one-cycle conversion request
  logic [SENS_W-1:0] lsn;        // averaged north level
  logic [SENS_W-1:0] lse;        // averaged east level
  logic [SENS_W-1:0] lss;        // averaged south level
  logic [SENS_W-1:0] lsw;        // averaged west level
  logic              upd;        // one-cycle pulse when lsn..lsw commit
  logic              adc_err;    // sticky conversion-timeout flag

  modport master (
    input  adc_data, adc_done,
    output adc_sel, adc_start, lsn, lse, lss, lsw, upd, adc_err
  );

  modport slave (
    output adc_data, adc_done,
    input  adc_sel, adc_start, lsn, lse, lss, lsw, upd, adc_err
  );

endinterface

// File: rtl/solar_sensor_sampler_chan_avg.sv
// Purpose : per-channel accumulator, sample counter and averaging shift.
// Latency : done_o/avg_o are combinational on the add_i cycle of the last sample.
// Backpres: none; one sample is absorbed on every add_i cycle.
// Ports   : clk, rst; clear_i drops a partial average; add_i + sample_i add one
//           sample; done_o flags the final sample, avg_o is the truncated mean.
module solar_chan_avg
  import solar_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              add_i,
  input  logic [SENS_W-1:0] sample_i,
  output logic              done_o,
  output logic [SENS_W-1:0] avg_o
);

  // Wide enough for 2^AVG_LOG2 full-scale samples, so the sum never wraps.
  localparam int AW = SENS_W + AVG_LOG2;

  logic [AW-1:0]       acc_q;
  logic [AW-1:0]       acc_d;
  logic [AVG_LOG2-1:0] cnt_q;

  assign acc_d  = acc_q + AW'(sample_i);
  // The count saturates at all-ones just before the final sample arrives.
  assign done_o = add_i & (&cnt_q);
  assign avg_o  = acc_d[AW-1:AVG_LOG2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (add_i) begin
      if (done_o) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/solar_sensor_sampler.sv
// Purpose : sequences N/E/S/W conversions on one muxed ADC and averages each.
// Latency : a full sweep is 4*SETTLE + 4*2^AVG_LOG2*(conv+2) + 1 cycles to upd.
// Backpres: none; waits on adc_done, and gives up after TIMEOUT cycles.
// Ports   : clk, rst (async, active-high); bus.master carries adc_data/adc_done
//           in and adc_sel/adc_start/lsn/lse/lss/lsw/upd/adc_err out.
module solar_sensor_sampler
  import solar_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  solar_sensor_sampler_if.master bus
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state_q;
  logic [1:0]        ch_q;
  logic [SW-1:0]     settle_q;
  logic [TW-1:0]     tmo_q;
  logic [SENS_W-1:0] sample_q;
  logic [SENS_W-1:0] sh_n_q, sh_e_q, sh_s_q;
  logic [SENS_W-1:0] lsn_q, lse_q, lss_q, lsw_q;
  logic              adc_start_q;
  logic              upd_q;
  logic              err_q;

  logic              acc_add;
  logic              tmo_hit;
  logic              avg_done;
  logic [SENS_W-1:0] avg;

  assign acc_add = (state_q == S_ACC);
  // A done arriving on the terminal-count cycle takes priority over the error.
  assign tmo_hit = (state_q == S_WAIT) && !bus.adc_done &&
                   (tmo_q == TW'(TIMEOUT - 1));

  solar_chan_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmo_hit),
    .add_i    (acc_add),
    .sample_i (sample_q),
    .done_o   (avg_done),
    .avg_o    (avg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_SEL;
      ch_q        <= CH_N;
      settle_q    <= '0;
      tmo_q       <= '0;
      sample_q    <= '0;
      sh_n_q      <= '0;
      sh_e_q      <= '0;
      sh_s_q      <= '0;
      lsn_q       <= '0;
      lse_q       <= '0;
      lss_q       <= '0;
      lsw_q       <= '0;
      adc_start_q <= 1'b0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      adc_start_q <= 1'b0;
      upd_q       <= 1'b0;
      case (state_q)
        S_SEL: begin
          if (settle_q == SW'(SETTLE - 1)) begin
            settle_q    <= '0;
            adc_start_q <= 1'b1;
            state_q     <= S_START;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        S_START: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.adc_done) begin
            sample_q <= bus.adc_data;
            state_q  <= S_ACC;
          end else if (tmo_hit) begin
            // Retry the same channel; the averager drops its partial sum.
            err_q   <= 1'b1;
            state_q <= S_SEL;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_ACC: begin
          if (!avg_done) begin
            adc_start_q <= 1'b1;
            state_q     <= S_START;
          end else if (ch_q == CH_W) begin
            // West goes straight to the output; all four levels and upd
            // become visible together during the S_COMMIT cycle.
            lsn_q   <= sh_n_q;
            lse_q   <= sh_e_q;
            lss_q   <= sh_s_q;
            lsw_q   <= avg;
            upd_q   <= 1'b1;
            state_q <= S_COMMIT;
          end else begin
            case (ch_q)
              CH_N:    sh_n_q <= avg;
              CH_E:    sh_e_q <= avg;
              default: sh_s_q <= avg;
            endcase
            ch_q    <= ch_q + 2'd1;
            state_q <= S_SEL;
          end
        end
        S_COMMIT: begin
          ch_q    <= CH_N;
          state_q <= S_SEL;
        end
        default: state_q <= S_SEL;
      endcase
    end
  end

  // adc_sel is the channel register itself, which only moves on S_SEL entry.
  assign bus.adc_sel   = ch_q;
  assign bus.adc_start = adc_start_q;
  assign bus.lsn       = lsn_q;
  assign bus.lse       = lse_q;
  assign bus.lss       = lss_q;
  assign bus.lsw       = lsw_q;
  assign bus.upd       = upd_q;
  assign bus.adc_err   = err_q;

endmodule
